nnrv_mem_arb: RTL

NNRV_MEM_ARB -- requirements
Module: nnrv_mem_arb

---
 rtl/nnrv_mem_arb_pkg.sv | 16 +
 rtl/nnrv_mem_arb_if.sv | 51 +++++
 rtl/nnrv_mem_arb.sv | 86 ++++++++
 3 files changed

// File: rtl/nnrv_mem_arb_pkg.sv
// nnrv_mem_arb_pkg
// Shared definitions for the fetch/data memory arbiter:
//   owner_e     - response-tag owner encoding (fetch = 0, data = 1)
//   FETCH_MASK  - byte mask driven to the RAM for instruction fetches
//   RUN_W       - width of the data-run counter
package nnrv_mem_arb_pkg;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    localparam logic [3:0] FETCH_MASK = 4'b1111;
    localparam int unsigned RUN_W      = 4;

endpackage

// File: rtl/nnrv_mem_arb_if.sv
// nnrv_mem_arb_if
// Bundles the fetch port, data port and single-port RAM port of the arbiter.
//   slave  : arbiter view (requests and RAM read data in; grants, rvalid/rdata, RAM controls out)
//   master : environment view (requesters plus RAM model)
// Parameters: XLEN (data/address width), ADDR_WIDTH (RAM word-address bits).
interface nnrv_mem_arb_if #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned ADDR_WIDTH = 8
);
    // fetch port
    logic                  i_if_req;
    logic [XLEN-1:0]       i_if_addr;
    logic                  o_if_gnt;
    logic                  o_if_rvalid;
    logic [XLEN-1:0]       o_if_rdata;
    // data port
    logic                  i_d_req;
    logic                  i_d_we;
    logic [XLEN-1:0]       i_d_addr;
    logic [3:0]            i_d_mask;
    logic [XLEN-1:0]       i_d_wdata;
    logic                  o_d_gnt;
    logic                  o_d_rvalid;
    logic [XLEN-1:0]       o_d_rdata;
    // RAM port
    logic                  o_ram_en;
    logic                  o_ram_we;
    logic [ADDR_WIDTH-1:0] o_ram_addr;
    logic [3:0]            o_ram_mask;
    logic [XLEN-1:0]       o_ram_wdata;
    logic [XLEN-1:0]       i_ram_rdata;

    modport slave (
        input  i_if_req, i_if_addr,
        output o_if_gnt, o_if_rvalid, o_if_rdata,
        input  i_d_req, i_d_we, i_d_addr, i_d_mask, i_d_wdata,
        output o_d_gnt, o_d_rvalid, o_d_rdata,
        output o_ram_en, o_ram_we, o_ram_addr, o_ram_mask, o_ram_wdata,
        input  i_ram_rdata
    );

    modport master (
        output i_if_req, i_if_addr,
        input  o_if_gnt, o_if_rvalid, o_if_rdata,
        output i_d_req, i_d_we, i_d_addr, i_d_mask, i_d_wdata,
        input  o_d_gnt, o_d_rvalid, o_d_rdata,
        input  o_ram_en, o_ram_we, o_ram_addr, o_ram_mask, o_ram_wdata,
        output i_ram_rdata
    );

endinterface

// File: rtl/nnrv_mem_arb.sv
// nnrv_mem_arb
// Arbitrates a fetch requester and a data requester onto one single-port RAM
// with one-cycle read latency. Data wins by default; a data-run counter bounds
// how many consecutive data grants may pass while fetch waits (MAX_D_RUN).
// Ports:
//   i_clk  - clock
//   i_rst  - asynchronous active-high reset; all outputs held at 0 while set
//   bus    - nnrv_mem_arb_if.slave: fetch port, data port and RAM port
module nnrv_mem_arb
    import nnrv_mem_arb_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned MAX_D_RUN  = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    nnrv_mem_arb_if.slave bus
);

    logic [RUN_W-1:0] run_cnt;
    logic [RUN_W-1:0] run_cnt_nxt;
    logic             tag_valid;
    owner_e           tag_owner;
    logic             d_gnt;
    logic             if_gnt;
    logic             d_blocked;

    // Grant decision and data-run counter update.
    // Grants are gated by i_rst so nothing reaches the RAM during reset.
    always_comb begin
        d_blocked   = bus.i_if_req && (run_cnt == RUN_W'(MAX_D_RUN));
        d_gnt       = !i_rst && bus.i_d_req && !d_blocked;
        if_gnt      = !i_rst && bus.i_if_req && !d_gnt;
        run_cnt_nxt = run_cnt;
        if (!bus.i_if_req || if_gnt) begin
            run_cnt_nxt = '0;
        end else if (d_gnt && (run_cnt != RUN_W'(MAX_D_RUN))) begin
            run_cnt_nxt = run_cnt + 1'b1;
        end
    end

    // Response tag: marks the cycle after a read grant and who owns it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            run_cnt   <= '0;
            tag_valid <= 1'b0;
            tag_owner <= OWN_IF;
        end else begin
            run_cnt   <= run_cnt_nxt;
            tag_valid <= (d_gnt && !bus.i_d_we) || if_gnt;
            tag_owner <= d_gnt ? OWN_D : OWN_IF;
        end
    end

    // RAM port is a combinational mux of the granted requester.
    always_comb begin
        bus.o_ram_en    = 1'b0;
        bus.o_ram_we    = 1'b0;
        bus.o_ram_addr  = '0;
        bus.o_ram_mask  = '0;
        bus.o_ram_wdata = '0;
        if (d_gnt) begin
            bus.o_ram_en    = 1'b1;
            bus.o_ram_we    = bus.i_d_we;
            bus.o_ram_addr  = bus.i_d_addr[ADDR_WIDTH-1:0];
            bus.o_ram_mask  = bus.i_d_mask;
            bus.o_ram_wdata = bus.i_d_wdata;
        end else if (if_gnt) begin
            bus.o_ram_en    = 1'b1;
            bus.o_ram_addr  = bus.i_if_addr[ADDR_WIDTH-1:0];
            bus.o_ram_mask  = FETCH_MASK;
        end
    end

    // Read data is steered to the tag owner only; the other side sees 0.
    always_comb begin
        bus.o_if_gnt    = if_gnt;
        bus.o_d_gnt     = d_gnt;
        bus.o_if_rvalid = tag_valid && (tag_owner == OWN_IF);
        bus.o_d_rvalid  = tag_valid && (tag_owner == OWN_D);
        bus.o_if_rdata  = bus.o_if_rvalid ? bus.i_ram_rdata : {XLEN{1'b0}};
        bus.o_d_rdata   = bus.o_d_rvalid  ? bus.i_ram_rdata : {XLEN{1'b0}};
    end

endmodule
